regfile_param: RTL and testbench
================================

# regfile_param

Parametrised MIPS general-purpose register file for the single-cycle and pipelined datapaths. It provides two asynchronous read ports, one data write port and a dedicated link-write port for `jal`. It adds synchronous clearing on reset, a hardwired-zero register 0, and a per-register busy scoreboard for pending load results. Optional write-to-read bypass is available. It sits between decode (read addresses), writeback (write port) and the control unit (`Jal`, load issue).

## Interface
- `DATA_WIDTH`, 32, register and data width in bits
- `ADDR_WIDTH`, 5, register address width; depth `NUM_REGS = 2**ADDR_WIDTH`
- `LINK_REG`, 31, register written by the link port; must be nonzero and less than `NUM_REGS`
- `LINK_OFFSET`, 1, value added to `PcOut` for the return address (word-addressed PC)

Ports:
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high. Clears all registers and busy bits.
- `ReadReg1`, `ReadReg2` in `ADDR_WIDTH`: read addresses.
- `WriteReg` in `ADDR_WIDTH`, `WriteData` in `DATA_WIDTH`, `RegWrite` in 1: data write port.
- `PcOut` in `DATA_WIDTH`, `Jal` in 1: link write port.
- `SetBusy` in 1, `BusyReg` in `ADDR_WIDTH`: mark a register as awaiting a load result.
- `DataRead1`, `DataRead2` out `DATA_WIDTH`: read data.
- `Busy1`, `Busy2` out 1: busy bit of `ReadReg1` / `ReadReg2`.

## Operation
- Storage is `NUM_REGS` x `DATA_WIDTH`. Register 0 always reads 0, is never written and is never busy.
- Reads are combinational from `ReadReg*`.
- The edge action is chosen in this priority order:
  - `Reset`: all registers = 0, all busy bits = 0. Writes, link and `SetBusy` in the same cycle are ignored.
  - `RegWrite` with `WriteReg != 0`: `regs[WriteReg] <= WriteData`, and `busy[WriteReg]` is cleared.
  - `Jal`: `regs[LINK_REG] <= PcOut + LINK_OFFSET`, truncated to `DATA_WIDTH` (wraps modulo 2^`DATA_WIDTH`), and `busy[LINK_REG]` is cleared.
  - The data write and the link write happen together when their targets differ.
  - If `RegWrite` and `Jal` both target `LINK_REG`, the link value wins.
  - `SetBusy` with `BusyReg != 0`: `busy[BusyReg] <= 1`.
  - If `SetBusy` targets the same register as a write-clear in the same cycle, set wins: the new load is outstanding, the old result is retired.
- `Busy1 = busy[ReadReg1]` and `Busy2 = busy[ReadReg2]`, combinational. Both are 0 for address 0.
- Busy bits do not affect the read data. The hazard/stall decision belongs to the hazard unit.

## Timing
- Read latency is 0 cycles (combinational).
- Write latency: a write on edge N is visible on `DataRead*` after edge N. Same-cycle visibility depends on `REGFILE_BYPASS_EN`.
- Busy set on edge N: `Busy*` is 1 after edge N, until the edge on which the register is written or reset.
- After reset, every `DataRead*` and `Busy*` output is 0 for all addresses until the first write.
- Reset asserted mid-operation, e.g. with a load outstanding: scoreboard cleared next edge, and the pending load's later write still lands normally.
- No handshake; every input is sampled every edge.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-first forwarding.
  - If `RegWrite` is high and `WriteReg == ReadRegX != 0`, `DataReadX = WriteData` in the same cycle.
  - If `Jal` is high and `ReadRegX == LINK_REG`, `DataReadX = PcOut + LINK_OFFSET`; link has priority over the data write.
  - `BusyX` for a register being cleared this cycle reads 0, unless `SetBusy` targets the same register.
- Not defined: reads return stored values only. Same-cycle writes become visible after the edge.

## Test plan
- Reset, then read all 32 addresses -> every `DataRead*` = 0 and every `Busy*` = 0. Write 0xDEADBEEF to reg 0 -> reads 0.
- `RegWrite` reg 5 = 0x12345678, read reg 5 in the same cycle:
  - with bypass: 0x12345678 before the edge;
  - without bypass: old value 0, then 0x12345678 after the edge.
- `Jal` with `PcOut` = 0x100 and `RegWrite` reg 31 = 0xAAAA in the same cycle -> reg 31 = 0x101. Then `PcOut` = 0xFFFFFFFF with `Jal` -> reg 31 = 0x00000000 (wrap).
- Scoreboard sequence:
  - `SetBusy` reg 8 -> `Busy1` = 1 with `ReadReg1` = 8.
  - `RegWrite` reg 8 together with `SetBusy` reg 8 -> stays 1.
  - `RegWrite` reg 8 alone -> 0.
- `SetBusy` reg 0 -> `Busy` stays 0.
- Reset asserted in the same cycle as `RegWrite` reg 3 = 7, `Jal`, and `SetBusy` reg 9 -> reg 3, reg 31, and `busy[9]` all 0 after the edge.
- Parameter sweep at `DATA_WIDTH` = 16, `ADDR_WIDTH` = 3, `LINK_REG` = 7: write/read all 8 registers -> 16-bit values round-trip, and `Jal` writes reg 7.

Source files
------------

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised MIPS register file with link port and load scoreboard
//
// Purpose:
//   NUM_REGS x DATA_WIDTH general-purpose register file with two
//   combinational read ports, one data write port, a dedicated link write
//   port for jal, and a per-register busy bit for outstanding loads.
//   Register 0 is hardwired to zero and is never busy.
//
// Optional feature macro:
//   REGFILE_BYPASS_EN - when defined, writes in the current cycle are
//   forwarded to the read ports (link value over data value), and busy
//   bits being retired this cycle read as 0 unless re-set by SetBusy.
//
// Ports:
//   Clk                 rising-edge clock for all state
//   Reset               synchronous active-high clear of registers and busy bits
//   ReadReg1/ReadReg2   read addresses
//   DataRead1/DataRead2 read data
//   Busy1/Busy2         busy bit of ReadReg1/ReadReg2
//   WriteReg/WriteData/RegWrite  data write port
//   PcOut/Jal           link write port (LINK_REG <= PcOut + LINK_OFFSET)
//   SetBusy/BusyReg     mark BusyReg as awaiting a load result

module regfile_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic [DATA_WIDTH-1:0] PcOut,
    input  logic                  Jal,
    input  logic                  SetBusy,
    input  logic [ADDR_WIDTH-1:0] BusyReg,
    output logic [DATA_WIDTH-1:0] DataRead1,
    output logic [DATA_WIDTH-1:0] DataRead2,
    output logic                  Busy1,
    output logic                  Busy2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LinkAddr = ADDR_WIDTH'(LINK_REG);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busyNext;
    logic [NUM_REGS-1:0]   clearMask;
    logic [NUM_REGS-1:0]   setMask;
    logic [DATA_WIDTH-1:0] linkValue;
    logic                  dataWriteEn;

    // Return address wraps modulo 2**DATA_WIDTH by construction.
    assign linkValue = PcOut + DATA_WIDTH'(LINK_OFFSET);

    // The link write owns LINK_REG when both ports target it.
    assign dataWriteEn = RegWrite && (WriteReg != '0) && !(Jal && (WriteReg == LinkAddr));

    always_comb begin
        clearMask = '0;
        setMask   = '0;
        if (RegWrite && (WriteReg != '0)) begin
            clearMask = clearMask | (NUM_REGS'(1) << WriteReg);
        end
        if (Jal) begin
            clearMask = clearMask | (NUM_REGS'(1) << LinkAddr);
        end
        if (SetBusy && (BusyReg != '0)) begin
            setMask = NUM_REGS'(1) << BusyReg;
        end
        // Set is applied after clear: a new load outranks retiring the old one.
        busyNext = ((busy & ~clearMask) | setMask) & ~NUM_REGS'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            regs <= '{default: '0};
            busy <= '0;
        end else begin
            if (dataWriteEn) begin
                regs[WriteReg] <= WriteData;
            end
            if (Jal) begin
                regs[LinkAddr] <= linkValue;
            end
            busy <= busyNext;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NUM_REGS-1:0] retireOnly;

    // Registers being cleared this cycle without being re-marked busy.
    assign retireOnly = clearMask & ~setMask;

    always_comb begin
        DataRead1 = regs[ReadReg1];
        if (Jal && (ReadReg1 == LinkAddr)) begin
            DataRead1 = linkValue;
        end else if (RegWrite && (WriteReg == ReadReg1)) begin
            DataRead1 = WriteData;
        end
        if (ReadReg1 == '0) begin
            DataRead1 = '0;
        end
    end

    always_comb begin
        DataRead2 = regs[ReadReg2];
        if (Jal && (ReadReg2 == LinkAddr)) begin
            DataRead2 = linkValue;
        end else if (RegWrite && (WriteReg == ReadReg2)) begin
            DataRead2 = WriteData;
        end
        if (ReadReg2 == '0) begin
            DataRead2 = '0;
        end
    end

    assign Busy1 = busy[ReadReg1] && !retireOnly[ReadReg1] && (ReadReg1 != '0);
    assign Busy2 = busy[ReadReg2] && !retireOnly[ReadReg2] && (ReadReg2 != '0);
`else
    assign DataRead1 = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
    assign DataRead2 = (ReadReg2 == '0) ? '0 : regs[ReadReg2];
    assign Busy1     = busy[ReadReg1] && (ReadReg1 != '0);
    assign Busy2     = busy[ReadReg2] && (ReadReg2 != '0);
`endif

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param

module tb_regfile_param;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Default-parameter instance
    logic        Reset, RegWrite, Jal, SetBusy;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg, BusyReg;
    logic [31:0] WriteData, PcOut, DataRead1, DataRead2;
    logic        Busy1, Busy2;

    // Small instance: 16-bit data, 8 registers, link reg 7
    logic        sReset, sRegWrite, sJal, sSetBusy;
    logic [2:0]  sReadReg1, sReadReg2, sWriteReg, sBusyReg;
    logic [15:0] sWriteData, sPcOut, sDataRead1, sDataRead2;
    logic        sBusy1, sBusy2;

    int vectors = 0;
    int miscompares = 0;

    // Reference state for the default instance
    logic [31:0] mRegs [32];
    logic        mBusy [32];

    regfile_param dut (
        .Clk(Clk), .Reset(Reset),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .PcOut(PcOut), .Jal(Jal),
        .SetBusy(SetBusy), .BusyReg(BusyReg),
        .DataRead1(DataRead1), .DataRead2(DataRead2),
        .Busy1(Busy1), .Busy2(Busy2)
    );

    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .LINK_REG(7), .LINK_OFFSET(1)) dutSmall (
        .Clk(Clk), .Reset(sReset),
        .ReadReg1(sReadReg1), .ReadReg2(sReadReg2),
        .WriteReg(sWriteReg), .WriteData(sWriteData), .RegWrite(sRegWrite),
        .PcOut(sPcOut), .Jal(sJal),
        .SetBusy(sSetBusy), .BusyReg(sBusyReg),
        .DataRead1(sDataRead1), .DataRead2(sDataRead2),
        .Busy1(sBusy1), .Busy2(sBusy2)
    );

    // Expected read value from the architectural rules, given current inputs
    function automatic logic [31:0] expData(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (Jal && a == 5'd31) return PcOut + 32'd1;
        if (RegWrite && WriteReg == a) return WriteData;
`endif
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((RegWrite && WriteReg == a) || (Jal && a == 5'd31)) && !(SetBusy && BusyReg == a))
            return 1'b0;
`endif
        return mBusy[a];
    endfunction

    // Apply one clock edge to the reference: reset, then data write,
    // then link (overrides), then busy set (overrides clear)
    task automatic modelCommit();
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                mRegs[i] = 32'h0;
                mBusy[i] = 1'b0;
            end
        end else begin
            if (RegWrite && WriteReg != 0) begin
                mRegs[WriteReg] = WriteData;
                mBusy[WriteReg] = 1'b0;
            end
            if (Jal) begin
                mRegs[31] = PcOut + 32'd1;
                mBusy[31] = 1'b0;
            end
            if (SetBusy && BusyReg != 0) mBusy[BusyReg] = 1'b1;
        end
    endtask

    task automatic setIdle();
        Reset = 0; RegWrite = 0; Jal = 0; SetBusy = 0;
        WriteReg = 0; WriteData = 0; PcOut = 0; BusyReg = 0;
    endtask

    // Clock one edge with the currently driven inputs, then go idle
    task automatic tick();
        @(posedge Clk);
        modelCommit();
        #1;
        setIdle();
        #1;
    endtask

    task automatic test_reset();
        setIdle();
        Reset = 1; RegWrite = 1; WriteReg = 5'd3; WriteData = 32'h1234;
        tick();
        for (int a = 0; a < 32; a++) begin
            ReadReg1 = 5'(a);
            ReadReg2 = 5'(31 - a);
            #1;
            vectors++;
            if (DataRead1 !== 32'h0 || DataRead2 !== 32'h0 || Busy1 !== 1'b0 || Busy2 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_clear addr=%0d got d1=%h d2=%h b1=%b b2=%b want all 0",
                         a, DataRead1, DataRead2, Busy1, Busy2);
            end
        end
        RegWrite = 1; WriteReg = 5'd0; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd0;
        #1;
        vectors++;
        if (DataRead1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reg0_same_cycle got %h want 0", DataRead1);
        end
        tick();
        ReadReg1 = 5'd0;
        #1;
        vectors++;
        if (DataRead1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reg0_after_write got %h want 0", DataRead1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        ReadReg1 = 5'd5;
        RegWrite = 1; WriteReg = 5'd5; WriteData = 32'h12345678;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'h12345678;
`else
        want = 32'h0;
`endif
        vectors++;
        if (DataRead1 !== want) begin
            miscompares++;
            $display("FAIL write_same_cycle got %h want %h", DataRead1, want);
        end
        tick();
        ReadReg1 = 5'd5;
        #1;
        vectors++;
        if (DataRead1 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL write_after_edge got %h want 12345678", DataRead1);
        end
    endtask

    task automatic test_jal();
        logic [31:0] want;
        ReadReg2 = 5'd31;
        Jal = 1; PcOut = 32'h100;
        RegWrite = 1; WriteReg = 5'd31; WriteData = 32'hAAAA;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'h101;
`else
        want = 32'h0;
`endif
        vectors++;
        if (DataRead2 !== want) begin
            miscompares++;
            $display("FAIL link_same_cycle got %h want %h", DataRead2, want);
        end
        tick();
        ReadReg2 = 5'd31;
        #1;
        vectors++;
        if (DataRead2 !== 32'h101) begin
            miscompares++;
            $display("FAIL link_priority got %h want 00000101", DataRead2);
        end
        Jal = 1; PcOut = 32'hFFFFFFFF;
        tick();
        ReadReg2 = 5'd31;
        #1;
        vectors++;
        if (DataRead2 !== 32'h0) begin
            miscompares++;
            $display("FAIL link_wrap got %h want 00000000", DataRead2);
        end
        Jal = 1; PcOut = 32'h400; RegWrite = 1; WriteReg = 5'd4; WriteData = 32'h55;
        tick();
        ReadReg1 = 5'd4; ReadReg2 = 5'd31;
        #1;
        vectors++;
        if (DataRead1 !== 32'h55 || DataRead2 !== 32'h401) begin
            miscompares++;
            $display("FAIL link_and_write got r4=%h r31=%h want 55 401", DataRead1, DataRead2);
        end
    endtask

    task automatic test_scoreboard();
        logic want;
        SetBusy = 1; BusyReg = 5'd8;
        tick();
        ReadReg1 = 5'd8; ReadReg2 = 5'd8;
        #1;
        vectors++;
        if (Busy1 !== 1'b1 || Busy2 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_set got b1=%b b2=%b want 1 1", Busy1, Busy2);
        end
        RegWrite = 1; WriteReg = 5'd8; WriteData = 32'h88; SetBusy = 1; BusyReg = 5'd8;
        #1;
        vectors++;
        if (Busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_set_wins_same_cycle got %b want 1", Busy1);
        end
        tick();
        ReadReg1 = 5'd8;
        #1;
        vectors++;
        if (Busy1 !== 1'b1 || DataRead1 !== 32'h88) begin
            miscompares++;
            $display("FAIL busy_set_wins got busy=%b data=%h want 1 00000088", Busy1, DataRead1);
        end
        RegWrite = 1; WriteReg = 5'd8; WriteData = 32'h99;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 1'b0;
`else
        want = 1'b1;
`endif
        vectors++;
        if (Busy1 !== want) begin
            miscompares++;
            $display("FAIL busy_clear_same_cycle got %b want %b", Busy1, want);
        end
        tick();
        ReadReg1 = 5'd8;
        #1;
        vectors++;
        if (Busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_clear got %b want 0", Busy1);
        end
        SetBusy = 1; BusyReg = 5'd0;
        tick();
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        vectors++;
        if (Busy1 !== 1'b0 || Busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_reg0 got b1=%b b2=%b want 0 0", Busy1, Busy2);
        end
    endtask

    task automatic test_reset_collision();
        RegWrite = 1; WriteReg = 5'd3; WriteData = 32'h33; SetBusy = 1; BusyReg = 5'd9;
        tick();
        Reset = 1; RegWrite = 1; WriteReg = 5'd3; WriteData = 32'h7;
        Jal = 1; PcOut = 32'h200; SetBusy = 1; BusyReg = 5'd9;
        tick();
        ReadReg1 = 5'd3; ReadReg2 = 5'd31;
        #1;
        vectors++;
        if (DataRead1 !== 32'h0 || DataRead2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_wins_data got r3=%h r31=%h want 0 0", DataRead1, DataRead2);
        end
        ReadReg1 = 5'd9;
        #1;
        vectors++;
        if (Busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wins_busy got %b want 0", Busy1);
        end
        RegWrite = 1; WriteReg = 5'd9; WriteData = 32'h99;
        tick();
        ReadReg1 = 5'd9;
        #1;
        vectors++;
        if (DataRead1 !== 32'h99 || Busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL late_load_lands got data=%h busy=%b want 00000099 0", DataRead1, Busy1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            Reset     = ($urandom_range(0, 31) == 0);
            RegWrite  = $urandom_range(0, 1);
            WriteReg  = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            Jal       = ($urandom_range(0, 5) == 0);
            PcOut     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            SetBusy   = $urandom_range(0, 1);
            BusyReg   = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
            ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
            ReadReg2  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            #1;
            vectors++;
            if (DataRead1 !== expData(ReadReg1) || DataRead2 !== expData(ReadReg2) ||
                Busy1 !== expBusy(ReadReg1) || Busy2 !== expBusy(ReadReg2)) begin
                miscompares++;
                $display("FAIL random n=%0d r1=%0d r2=%0d got %h %h %b %b want %h %h %b %b",
                         n, ReadReg1, ReadReg2, DataRead1, DataRead2, Busy1, Busy2,
                         expData(ReadReg1), expData(ReadReg2), expBusy(ReadReg1), expBusy(ReadReg2));
            end
            tick();
        end
    endtask

    task automatic test_param_sweep();
        logic [15:0] sExp [8];
        sRegWrite = 0; sJal = 0; sSetBusy = 0; sBusyReg = 0;
        sWriteReg = 0; sWriteData = 0; sPcOut = 0;
        sReset = 1;
        @(posedge Clk); #1;
        sReset = 0;
        for (int i = 0; i < 8; i++) begin
            sRegWrite  = 1;
            sWriteReg  = 3'(i);
            sWriteData = 16'($urandom);
            sExp[i]    = (i == 0) ? 16'h0 : sWriteData;
            @(posedge Clk); #1;
        end
        sRegWrite = 0;
        for (int i = 0; i < 8; i++) begin
            sReadReg1 = 3'(i);
            sReadReg2 = 3'(7 - i);
            #1;
            vectors++;
            if (sDataRead1 !== sExp[i] || sDataRead2 !== sExp[7 - i] || sBusy1 !== 1'b0) begin
                miscompares++;
                $display("FAIL small_roundtrip i=%0d got %h %h want %h %h",
                         i, sDataRead1, sDataRead2, sExp[i], sExp[7 - i]);
            end
        end
        sJal = 1; sPcOut = 16'h1234;
        @(posedge Clk); #1;
        sJal = 0;
        sReadReg1 = 3'd7;
        #1;
        vectors++;
        if (sDataRead1 !== 16'h1235) begin
            miscompares++;
            $display("FAIL small_link got %h want 1235", sDataRead1);
        end
        sJal = 1; sPcOut = 16'hFFFF;
        @(posedge Clk); #1;
        sJal = 0;
        #1;
        vectors++;
        if (sDataRead1 !== 16'h0000) begin
            miscompares++;
            $display("FAIL small_link_wrap got %h want 0000", sDataRead1);
        end
    endtask

    initial begin
        setIdle();
        ReadReg1 = 0; ReadReg2 = 0;
        sReset = 1; sRegWrite = 0; sJal = 0; sSetBusy = 0;
        sReadReg1 = 0; sReadReg2 = 0; sWriteReg = 0; sBusyReg = 0;
        sWriteData = 0; sPcOut = 0;
        for (int i = 0; i < 32; i++) begin
            mRegs[i] = 32'h0;
            mBusy[i] = 1'b0;
        end
        @(negedge Clk);
        test_reset();
        test_bypass();
        test_jal();
        test_scoreboard();
        test_reset_collision();
        test_random();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
